mem_access_stage: RTL

- Memory (M) stage controller of the RV32 pipeline, between the execute stage and the byte-banked data memory.
- Registers EX results and drives the data memory's 5-bit control, address and write-data inputs.
- Screens each access for faults and illegal widths.
- Aligns the one-cycle-late load data with its destination register and produces the writeback bundle.
- Honours a global stall and a pipeline flush.

---
 rtl/mem_access_stage_if.sv | 57 +++++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Bundles every signal of the memory stage except clock and reset.
//   slave  : the view of the memory stage controller itself.
//   master : the view of the surrounding pipeline, hazard unit and data memory.
//   Groups:
//     control   : stall, flush
//     EX side   : ex_valid, ex_ready, ex_mem_op, ex_addr, ex_wr_data, ex_rd, ex_rd_wen
//     RAM side  : ram_ctrl, ram_addr, ram_wr_data, ram_rd_data
//     hazard    : m1_rd, m1_is_load
//     writeback : wb_valid, wb_rd, wb_wen, wb_data
//     exception : exc_valid, exc_cause, exc_addr
interface mem_access_stage_if;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_mem_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wr_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;
  logic [4:0]  ram_ctrl;
  logic [31:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;
  logic [4:0]  m1_rd;
  logic        m1_is_load;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;

  modport slave (
    input  stall, flush,
    input  ex_valid, ex_mem_op, ex_addr, ex_wr_data, ex_rd, ex_rd_wen,
    output ex_ready,
    output ram_ctrl, ram_addr, ram_wr_data,
    input  ram_rd_data,
    output m1_rd, m1_is_load,
    output wb_valid, wb_rd, wb_wen, wb_data,
    output exc_valid, exc_cause, exc_addr
  );

  modport master (
    output stall, flush,
    output ex_valid, ex_mem_op, ex_addr, ex_wr_data, ex_rd, ex_rd_wen,
    input  ex_ready,
    input  ram_ctrl, ram_addr, ram_wr_data,
    output ram_rd_data,
    input  m1_rd, m1_is_load,
    input  wb_valid, wb_rd, wb_wen, wb_data,
    input  exc_valid, exc_cause, exc_addr
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage controller of the RV32 pipeline. The M1 register holds the
//   op being issued to the byte-banked data memory; the M2 register holds the
//   op whose load data arrives from the memory one cycle later and forms the
//   writeback bundle. Accesses are screened for illegal widths and for
//   addresses outside the DMEM_AW-bit data memory when they leave EX.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : mem_access_stage_if.slave (EX bundle, RAM port, hazard info,
//                writeback bundle, exception pulse, stall/flush)
//   ex_mem_op / ram_ctrl encoding: [4:2] funct3, [1] write, [0] memory access.
module mem_access_stage #(
  parameter int DMEM_AW = 16
) (
  input logic                clk,
  input logic                rst,
  mem_access_stage_if.slave  bus
);

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  // EX-side fault screening
  logic [2:0]         ex_funct3;
  logic               ex_write;
  logic               ex_access;
  logic [1:0]         ex_size_m1;
  logic [DMEM_AW:0]   ex_last_byte;
  logic               ex_illegal;
  logic               ex_out_of_range;
  logic               ex_fault;
  logic [3:0]         ex_cause;

  // M1 register
  logic               m1_valid_reg;
  logic [4:0]         m1_op_reg;
  logic [31:0]        m1_addr_reg;
  logic [31:0]        m1_wr_data_reg;
  logic [4:0]         m1_rd_reg;
  logic               m1_rd_wen_reg;
  logic               m1_fault_reg;
  logic [3:0]         m1_cause_reg;

  // M2 register
  logic               m2_valid_reg;
  logic [4:0]         m2_op_reg;
  logic [31:0]        m2_addr_reg;
  logic [4:0]         m2_rd_reg;
  logic               m2_rd_wen_reg;
  logic               m2_fault_reg;
  logic [3:0]         m2_cause_reg;
  logic               exc_pending_reg;

  logic               m2_is_load;
  logic               m2_is_store;

  assign ex_funct3 = bus.ex_mem_op[4:2];
  assign ex_write  = bus.ex_mem_op[1];
  assign ex_access = bus.ex_mem_op[0];

  always_comb begin
    ex_size_m1 = 2'd0;
    case (ex_funct3[1:0])
      2'b01:   ex_size_m1 = 2'd1;
      2'b10:   ex_size_m1 = 2'd3;
      default: ex_size_m1 = 2'd0;
    endcase

    // One extra bit catches an access whose last byte runs past the top of
    // memory; the address never wraps around to 0.
    ex_last_byte = {1'b0, bus.ex_addr[DMEM_AW-1:0]}
                 + {{(DMEM_AW-1){1'b0}}, ex_size_m1};

    // funct3[2] marks the unsigned load forms, which have no store counterpart.
    ex_illegal = ex_access & ((ex_funct3 == 3'b011) ||
                              (ex_funct3[2:1] == 2'b11) ||
                              (ex_funct3[2] && ex_write));

    ex_out_of_range = ex_access & ((|bus.ex_addr[31:DMEM_AW]) | ex_last_byte[DMEM_AW]);

    ex_fault = ex_illegal | ex_out_of_range;

    ex_cause = 4'd0;
    if (ex_illegal)
      ex_cause = CAUSE_ILLEGAL;
    else if (ex_out_of_range)
      ex_cause = ex_write ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
  end

  assign bus.ex_ready = ~bus.stall & ~bus.flush;

  // M1: flush wins over stall; an idle EX slot clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      m1_valid_reg   <= 1'b0;
      m1_op_reg      <= '0;
      m1_addr_reg    <= '0;
      m1_wr_data_reg <= '0;
      m1_rd_reg      <= '0;
      m1_rd_wen_reg  <= 1'b0;
      m1_fault_reg   <= 1'b0;
      m1_cause_reg   <= '0;
    end else if (bus.flush) begin
      m1_valid_reg   <= 1'b0;
    end else if (!bus.stall) begin
      m1_valid_reg   <= bus.ex_valid;
      if (bus.ex_valid) begin
        m1_op_reg      <= bus.ex_mem_op;
        m1_addr_reg    <= bus.ex_addr;
        m1_wr_data_reg <= bus.ex_wr_data;
        m1_rd_reg      <= bus.ex_rd;
        m1_rd_wen_reg  <= bus.ex_rd_wen;
        m1_fault_reg   <= ex_fault;
        m1_cause_reg   <= ex_cause;
      end
    end
  end

  // M2: the flushed M1 op must not advance, but M2 itself is never killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_valid_reg    <= 1'b0;
      m2_op_reg       <= '0;
      m2_addr_reg     <= '0;
      m2_rd_reg       <= '0;
      m2_rd_wen_reg   <= 1'b0;
      m2_fault_reg    <= 1'b0;
      m2_cause_reg    <= '0;
      exc_pending_reg <= 1'b0;
    end else if (!bus.stall) begin
      m2_valid_reg    <= m1_valid_reg & ~bus.flush;
      m2_op_reg       <= m1_op_reg;
      m2_addr_reg     <= m1_addr_reg;
      m2_rd_reg       <= m1_rd_reg;
      m2_rd_wen_reg   <= m1_rd_wen_reg;
      m2_fault_reg    <= m1_fault_reg;
      m2_cause_reg    <= m1_cause_reg;
      exc_pending_reg <= m1_valid_reg & m1_fault_reg & ~bus.flush;
    end
  end

  // Dropping ram_ctrl to zero during stall also makes the memory keep its
  // read register, so the load data already in M2 survives the stall.
  assign bus.ram_ctrl    = (m1_valid_reg && m1_op_reg[0] && !m1_fault_reg &&
                            !bus.stall && !bus.flush) ? m1_op_reg : 5'd0;
  assign bus.ram_addr    = m1_addr_reg;
  assign bus.ram_wr_data = m1_wr_data_reg;

  assign bus.m1_rd      = m1_rd_reg;
  assign bus.m1_is_load = m1_valid_reg & m1_op_reg[0] & ~m1_op_reg[1];

  assign m2_is_load  = m2_op_reg[0] & ~m2_op_reg[1];
  assign m2_is_store = m2_op_reg[0] &  m2_op_reg[1];

  assign bus.wb_valid = m2_valid_reg;
  assign bus.wb_rd    = m2_rd_reg;
  assign bus.wb_wen   = m2_valid_reg & m2_rd_wen_reg & (m2_rd_reg != 5'd0) &
                        ~m2_fault_reg & ~m2_is_store;
  // Memory returns loads already sign/zero-extended; other ops carry the ALU result.
  assign bus.wb_data  = (m2_valid_reg && m2_is_load && !m2_fault_reg) ?
                        bus.ram_rd_data : m2_addr_reg;

  // Held pending across a stall and shown only in a non-stalled cycle.
  assign bus.exc_valid = exc_pending_reg & ~bus.stall;
  assign bus.exc_cause = m2_cause_reg;
  assign bus.exc_addr  = m2_addr_reg;

endmodule
